// File: rtl/mem_access_stage.sv
// MEM pipeline stage: converts EX/MEM load/store control into single-beat
// Wishbone master cycles. Stores get their data placed on the correct byte
// lanes. Load data is sign- or zero-extended from the addressed byte or half.
// Non-memory instructions pass through to MEMWBREG with no added latency.
module mem_access_stage #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   // request from EX/MEM
   input  logic                  mem_read_in,
   input  logic                  mem_write_in,
   input  logic [2:0]            funct3_in,
   input  logic [ADDR_WIDTH-1:0] addr_in,
   input  logic [DATA_WIDTH-1:0] store_data_in,
   input  logic [ADDR_WIDTH-1:0] PC_in,
   input  logic [4:0]            rd_addr_in,
   input  logic                  MemtoReg_in,
   input  logic                  RegWrite_in,
   // towards MEMWBREG
   output logic [ADDR_WIDTH-1:0] PC_out,
   output logic [ADDR_WIDTH-1:0] ALU_result_out,
   output logic [4:0]            rd_addr_out,
   output logic                  MemtoReg_out,
   output logic                  RegWrite_out,
   output logic [DATA_WIDTH-1:0] memory_data_out,
   output logic                  stall_req,
   output logic                  misalign_err,
   // Wishbone master
   output logic                  wb_cyc_o,
   output logic                  wb_stb_o,
   output logic                  wb_we_o,
   output logic [ADDR_WIDTH-1:0] wb_adr_o,
   output logic [31:0]           wb_dat_o,
   output logic [3:0]            wb_sel_o,
   input  logic [31:0]           wb_dat_i,
   input  logic                  wb_ack_i
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                  state_q, state_d;
   logic                    cyc_q, cyc_d;
   logic                    we_q, we_d;
   logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
   logic [31:0]             dat_q, dat_d;
   logic [3:0]              sel_q, sel_d;
   logic [31:0]             rdata_q, rdata_d;
   logic [2:0]              funct3_q, funct3_d;
   logic [1:0]              off_q, off_d;

   logic                    is_load, is_store, is_req;
   logic                    size_ok, aligned, req_err, req_go;
   logic [3:0]              lane_sel;
   logic [31:0]             lane_dat;
   logic [7:0]              ld_byte;
   logic [15:0]             ld_half;
   logic [31:0]             ld_ext;

   // Decode request legality: size/sign code, direction and alignment.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      is_load  = mem_read_in;                      // read+write together counts as a load
      is_store = mem_write_in & ~mem_read_in;
      is_req   = is_load | is_store;
      size_ok  = 1'b0;
      aligned  = 1'b0;
      case (funct3_in)
         3'b000: begin size_ok = 1'b1;    aligned = 1'b1;                 end
         3'b001: begin size_ok = 1'b1;    aligned = ~addr_in[0];          end
         3'b010: begin size_ok = 1'b1;    aligned = (addr_in[1:0] == 2'b00); end
         3'b100: begin size_ok = is_load; aligned = 1'b1;                 end
         3'b101: begin size_ok = is_load; aligned = ~addr_in[0];          end
         default: begin size_ok = 1'b0;   aligned = 1'b0;                 end
      endcase
      req_go  = is_req & size_ok & aligned;
      req_err = is_req & ~(size_ok & aligned);
   end

   // Byte-enable and lane-replicated store data for the current request.
   always_comb begin
      lane_sel = 4'b1111;
      lane_dat = store_data_in;
      case (funct3_in[1:0])
         2'b00: begin
            lane_sel = 4'b0001 << addr_in[1:0];
            lane_dat = {4{store_data_in[7:0]}};
         end
         2'b01: begin
            lane_sel = 4'b0011 << addr_in[1:0];
            lane_dat = {2{store_data_in[15:0]}};
         end
         default: begin
            lane_sel = 4'b1111;
            lane_dat = store_data_in;
         end
      endcase
   end

   // Next-state and registered bus controls for the IDLE/BUSY/DONE sequence.
   always_comb begin
      state_d  = state_q;
      cyc_d    = cyc_q;
      we_d     = we_q;
      adr_d    = adr_q;
      dat_d    = dat_q;
      sel_d    = sel_q;
      rdata_d  = rdata_q;
      funct3_d = funct3_q;
      off_d    = off_q;
      case (state_q)
         IDLE: begin
            if (req_go) begin
               state_d  = BUSY;
               cyc_d    = 1'b1;
               we_d     = is_store;
               adr_d    = {addr_in[ADDR_WIDTH-1:2], 2'b00};
               dat_d    = is_store ? lane_dat : 32'h0;
               sel_d    = lane_sel;
               funct3_d = funct3_in;
               off_d    = addr_in[1:0];
            end
         end
         BUSY: begin
            if (wb_ack_i) begin
               state_d = DONE;
               cyc_d   = 1'b0;
               rdata_d = we_q ? 32'h0 : wb_dat_i;   // stores deliver no data
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and bus register update; reset aborts any bus cycle at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cyc_q    <= 1'b0;
         we_q     <= 1'b0;
         adr_q    <= '0;
         dat_q    <= 32'h0;
         sel_q    <= 4'h0;
         rdata_q  <= 32'h0;
         funct3_q <= 3'b000;
         off_q    <= 2'b00;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q  <= state_d;
         cyc_q    <= cyc_d;
         we_q     <= we_d;
         adr_q    <= adr_d;
         dat_q    <= dat_d;
         sel_q    <= sel_d;
         rdata_q  <= rdata_d;
         funct3_q <= funct3_d;
         off_q    <= off_d;
      end
   end

   // Extract and extend the addressed byte/half of the captured word.
   always_comb begin
      ld_byte = rdata_q[{off_q, 3'b000} +: 8];
      ld_half = rdata_q[{off_q[1], 4'b0000} +: 16];
      case (funct3_q)
         3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_ext = {24'h0, ld_byte};
         3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_ext = {16'h0, ld_half};
         default: ld_ext = rdata_q;
      endcase
   end

   assign stall_req       = ((state_q == IDLE) & req_go) | (state_q == BUSY);
   assign misalign_err    = reset & (state_q == IDLE) & req_err;
   assign memory_data_out = (state_q == DONE) ? ld_ext : '0;

   assign PC_out         = PC_in;
   assign ALU_result_out = addr_in;
   assign rd_addr_out    = rd_addr_in;
   assign MemtoReg_out   = MemtoReg_in;
   assign RegWrite_out   = RegWrite_in & ~misalign_err;

   assign wb_cyc_o = cyc_q;
   assign wb_stb_o = cyc_q;
   assign wb_we_o  = we_q;
   assign wb_adr_o = adr_q;
   assign wb_dat_o = dat_q;
   assign wb_sel_o = sel_q;

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline MEM stage of the RISC-V core: sits between the EX/MEM register and MEMWBREG and turns load/store control from EX/MEM into Wishbone single-beat master cycles. It handles byte-lane placement for stores and sign/zero extension for loads. It holds the pipeline with `stall_req` while a bus cycle is outstanding. Non-memory instructions pass straight through to MEMWBREG with no added latency.

## Interface
- ADDR_WIDTH, 32, address width of PC and bus address
- DATA_WIDTH, 32, data width; fixed at 32 for byte-lane logic
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset (low = reset)
- mem_read_in / mem_write_in  in  1 each  load / store request from EX/MEM; both high is illegal and is treated as a load
- funct3_in  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- addr_in  in  ADDR_WIDTH  effective address (ALU result)
- store_data_in  in  DATA_WIDTH  rs2 value, unshifted
- PC_in, rd_addr_in[4:0], MemtoReg_in, RegWrite_in  in  pass-through fields
- PC_out, ALU_result_out, rd_addr_out, MemtoReg_out, RegWrite_out  out  combinational pass-through to MEMWBREG; ALU_result_out = addr_in
- memory_data_out  out  DATA_WIDTH  extended load data to MEMWBREG
- stall_req  out  1  holds IF..EX/MEM and stalls MEMWBREG (flush_and_stall[0])
- misalign_err  out  1  one-cycle flag: misaligned or illegal-funct3 access
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone master controls
- wb_adr_o  out  ADDR_WIDTH  word-aligned address ({addr[31:2],2'b00})
- wb_dat_o  out  32  store data shifted to the byte lane
- wb_sel_o  out  4  byte enables
- wb_dat_i  in  32, wb_ack_i  in  1  slave response

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE, with no request: outputs pass through, stall_req=0, memory_data_out=0.
- IDLE, with a request that is aligned and legal: stall_req=1 combinationally. Bus outputs are registered from the inputs. Next state is BUSY.
- BUSY: cyc=stb=1; bus outputs stay stable; stall_req=1. On wb_ack_i: capture wb_dat_i, drop cyc/stb, go to DONE.
- DONE: stall_req=0; memory_data_out = extended captured data. MEMWBREG latches at the end of this cycle. Next state is IDLE.
- Alignment rules: W needs addr[1:0]=0; H/HU needs addr[0]=0; B is always aligned.
- Misaligned access, illegal funct3 (011, 110, 111), or store with funct3 100/101: no bus cycle, misalign_err=1 for that cycle, stall_req=0, memory_data_out=0, and RegWrite_out is forced to 0.
- Store lanes: SB sel=4'b0001<<off, dat={4{b}}; SH sel=4'b0011<<off, dat={2{h}}; SW sel=4'hF. off=addr[1:0].
- Load extraction: the byte/half is selected by off. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Request inputs must stay constant while stall_req=1. The block relies on this upstream hold and does not re-sample them in BUSY.

## Timing
- Reset (reset=0, asynchronous): state=IDLE, cyc=stb=we=0, adr=0, dat_o=0, sel=0, captured data=0, misalign_err=0. Combinational outputs follow the inputs.
- Latency with ack in the first BUSY cycle:
  - cycle 0: IDLE, request seen, stall=1
  - cycle 1: BUSY, ack
  - cycle 2: DONE, stall=0
  - Total: 3 cycles. Each extra wait cycle adds 1.
- Reset asserted mid-BUSY: cyc/stb drop immediately and no data is delivered. The slave must tolerate cycle abort.
- An ack in IDLE or DONE is ignored.
- A new request in the cycle after DONE starts a fresh transaction. There is no back-to-back reuse of DONE.
- misalign_err is combinational in IDLE and never asserted in BUSY/DONE.

## Test plan
- LW addr 0x8000_0104, ack after 2 wait cycles, wb_dat_i=0xDEAD_BEEF -> adr 0x8000_0104, sel F, stall high 4 cycles, DONE memory_data_out=0xDEADBEEF.
- LB addr 0x...03, wb_dat_i=0x80FF_0000 -> sel 1000, memory_data_out=0xFFFF_FF80; LBU same -> 0x0000_0080.
- SH addr 0x...02, store_data_in=0x1234_ABCD -> we=1, sel 1100, wb_dat_o=0xABCD_ABCD, memory_data_out=0.
- LW addr 0x...06 -> no cyc, misalign_err=1 one cycle, stall_req=0, RegWrite_out=0.
- Non-memory op (mem_read=mem_write=0), RegWrite=1 rd=5 -> zero-cycle pass-through, stall_req=0, no bus activity.
- Reset pulled low during BUSY -> cyc/stb=0 same cycle, FSM IDLE after release, next LW completes normally.
